// File: rtl/rock_pkg.sv
// Shared definitions for the rocker cry-stress input stage.
// Default widths/thresholds, sample/level types and the hysteresis state encoding.
// No ports; imported by stress_detector.
package rock_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int THR_HI_DEF   = 160;
   localparam int THR_LO_DEF   = 96;
   localparam int HOLD_WIN_DEF = 12;

   typedef logic [DATA_W_DEF-1:0] sample_t;
   typedef logic [DATA_W_DEF-1:0] level_t;

   typedef enum logic {
      CALM     = 1'b0,
      STRESSED = 1'b1
   } hyst_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous 1-bit strobe plus rising-edge detector.
// Ports: clk, reset (async active-high), d_i (async input), rise_o (1-clk pulse on
// synchronised rising edge, two clocks after d_i is first sampled high).
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/stress_detector.sv
// Cry-stress input stage: window-averages DSP samples, applies hysteresis, tracks
// stress continuity and watches for a stalled DSP (sticky error).
// Ports: clk, reset (async active-high), tick, dsp_data, dsp_ready (async strobe),
// level, level_valid, stress_low, stress_continu, error.
module stress_detector
   import rock_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int WIN_LOG2 = 4,
   parameter int THR_HI   = THR_HI_DEF,
   parameter int THR_LO   = THR_LO_DEF,
   parameter int HOLD_WIN = HOLD_WIN_DEF,
   parameter int TIMEOUT  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic [DATA_W-1:0] dsp_data,
   input  logic              dsp_ready,
   output logic [DATA_W-1:0] level,
   output logic              level_valid,
   output logic              stress_low,
   output logic              stress_continu,
   output logic              error
);

   localparam int ACC_W = DATA_W + WIN_LOG2;
   localparam int HW_W  = $clog2(HOLD_WIN + 1);
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   localparam logic [DATA_W-1:0] THR_HI_L  = DATA_W'(THR_HI);
   localparam logic [DATA_W-1:0] THR_LO_L  = DATA_W'(THR_LO);
   localparam logic [HW_W-1:0]   HOLD_L    = HW_W'(HOLD_WIN);
   localparam logic [WD_W-1:0]   TIMEOUT_L = WD_W'(TIMEOUT);

   generate
      if (THR_LO >= THR_HI || WIN_LOG2 < 1 || HOLD_WIN < 1 || TIMEOUT < 1) begin : g_param_chk
         $error("stress_detector: illegal parameter combination");
      end
   endgenerate

   // ---------------------------------------------------------------- acceptance
   logic accept;

   sync_edge u_sync_edge (
      .clk    (clk),
      .reset  (reset),
      .d_i    (dsp_ready),
      .rise_o (accept)
   );

   // --------------------------------------------------------------- accumulator
   // The sample is registered on the accept clock and folded into the window on
   // the following clock, so the window result lands one clock after capture.
   logic [DATA_W-1:0]   samp_q;
   logic                samp_vld_q;
   logic [ACC_W-1:0]    acc_q;
   logic [WIN_LOG2-1:0] cnt_q;
   logic [DATA_W-1:0]   level_q;
   logic                level_valid_q;
   logic [ACC_W-1:0]    sum;

   assign sum = acc_q + ACC_W'(samp_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         samp_q        <= '0;
         samp_vld_q    <= 1'b0;
         acc_q         <= '0;
         cnt_q         <= '0;
         level_q       <= '0;
         level_valid_q <= 1'b0;
      end else begin
         samp_vld_q    <= accept;
         level_valid_q <= 1'b0;
         if (accept) begin
            samp_q <= dsp_data;
         end
         if (samp_vld_q) begin
            if (cnt_q == {WIN_LOG2{1'b1}}) begin
               // Truncating divide by the window size.
               level_q       <= sum[ACC_W-1:WIN_LOG2];
               level_valid_q <= 1'b1;
               acc_q         <= '0;
               cnt_q         <= '0;
            end else begin
               acc_q <= sum;
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   // --------------------------------------------------- hysteresis + continuity
   hyst_state_e       state_q, state_d;
   logic [HW_W-1:0]   win_cnt_q, win_cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= CALM;
         win_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         win_cnt_q <= win_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      win_cnt_d = win_cnt_q;
      if (level_valid_q) begin
         if (level_q >= THR_HI_L) begin
            state_d = STRESSED;
         end else if (level_q <= THR_LO_L) begin
            state_d = CALM;
         end
         // Continuity follows the state the window ends in, not the raw level.
         if (state_d == STRESSED) begin
            if (win_cnt_q != HOLD_L) begin
               win_cnt_d = win_cnt_q + HW_W'(1);
            end
         end else begin
            win_cnt_d = '0;
         end
      end
   end

   // ------------------------------------------------------------------ watchdog
   logic [WD_W-1:0] wd_q;
   logic            error_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_q    <= '0;
         error_q <= 1'b0;
      end else begin
         if (accept) begin
            wd_q <= '0;               // accept beats a coincident tick
         end else if (tick && !error_q) begin
            wd_q <= wd_q + WD_W'(1);
            if (wd_q == TIMEOUT_L - WD_W'(1)) begin
               error_q <= 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------- outputs
   assign level          = level_q;
   assign level_valid    = level_valid_q;
   assign stress_low     = (state_q == CALM);
   assign stress_continu = (win_cnt_q == HOLD_L);
   assign error          = error_q;

endmodule

// File: tb/tb_stress_detector.sv
// Directed self-checking bench for stress_detector.
// Drives async-style ready strobes and ticks, checks reset, averaging, latency,
// hysteresis, continuity, held-ready and watchdog behaviour.
module tb_stress_detector;

   logic       clk;
   logic       reset;
   logic       tick;
   logic [7:0] dsp_data;
   logic       dsp_ready;
   logic [7:0] level;
   logic       level_valid;
   logic       stress_low;
   logic       stress_continu;
   logic       error;

   int n_assert = 0;
   int n_fail   = 0;
   int lv_cnt   = 0;
   int lv0;

   stress_detector dut (
      .clk            (clk),
      .reset          (reset),
      .tick           (tick),
      .dsp_data       (dsp_data),
      .dsp_ready      (dsp_ready),
      .level          (level),
      .level_valid    (level_valid),
      .stress_low     (stress_low),
      .stress_continu (stress_continu),
      .error          (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (level_valid === 1'b1) lv_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send_sample(input logic [7:0] v);
      @(posedge clk);
      #2 dsp_data = v;
      dsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2 dsp_ready = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   // Tick asserted exactly over the clock edge at which the sample is accepted.
   task automatic send_sample_tick(input logic [7:0] v);
      @(posedge clk);
      #2 dsp_data = v;
      dsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2 tick = 1'b1;
      @(posedge clk);
      #2 tick = 1'b0;
      dsp_ready = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic send_window(input logic [7:0] v);
      for (int i = 0; i < 16; i++) send_sample(v);
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2 tick = 1'b1;
         @(posedge clk);
         #2 tick = 1'b0;
      end
   endtask

   initial begin
      reset     = 1'b0;
      tick      = 1'b0;
      dsp_data  = 8'd0;
      dsp_ready = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_level",    32'(level), 32'd0);
      check("rst_lvalid",   32'(level_valid), 32'd0);
      check("rst_slow",     32'(stress_low), 32'd1);
      check("rst_continu",  32'(stress_continu), 32'd0);
      check("rst_error",    32'(error), 32'd0);
      #1 reset = 1'b0;

      // Partial window of 200s discarded by an asynchronous reset.
      for (int i = 0; i < 7; i++) send_sample(8'd200);
      #3 reset = 1'b1;
      #1;
      check("midrst_level", 32'(level), 32'd0);
      check("midrst_slow",  32'(stress_low), 32'd1);
      @(posedge clk);
      #2 reset = 1'b0;
      lv0 = lv_cnt;
      send_window(8'd50);
      check("win50_level",  32'(level), 32'd50);
      check("win50_lvcnt",  32'(lv_cnt - lv0), 32'd1);
      check("win50_slow",   32'(stress_low), 32'd1);

      // Window of 200: exact latency from last ready rise.
      for (int i = 0; i < 15; i++) send_sample(8'd200);
      @(posedge clk);
      #2 dsp_data = 8'd200;
      dsp_ready = 1'b1;
      @(posedge clk); #1;
      check("lat_e1_slow",  32'(stress_low), 32'd1);
      @(posedge clk);
      @(posedge clk); #1;
      check("lat_e3_lvalid", 32'(level_valid), 32'd0);
      @(posedge clk); #1;
      check("lat_e4_lvalid", 32'(level_valid), 32'd1);
      check("lat_e4_level",  32'(level), 32'd200);
      check("lat_e4_slow",   32'(stress_low), 32'd1);
      @(posedge clk); #1;
      check("lat_e5_slow",   32'(stress_low), 32'd0);
      check("lat_e5_lvalid", 32'(level_valid), 32'd0);
      #1 dsp_ready = 1'b0;
      repeat (3) @(posedge clk);

      // Hysteresis band.
      send_window(8'd120);
      check("hyst120_level", 32'(level), 32'd120);
      check("hyst120_slow",  32'(stress_low), 32'd0);
      send_window(8'd90);
      check("hyst90_level",  32'(level), 32'd90);
      check("hyst90_slow",   32'(stress_low), 32'd1);

      // Continuity after 12 consecutive stressed windows.
      for (int w = 0; w < 11; w++) send_window(8'd200);
      check("cont11_continu", 32'(stress_continu), 32'd0);
      check("cont11_slow",    32'(stress_low), 32'd0);
      send_window(8'd200);
      check("cont12_continu", 32'(stress_continu), 32'd1);
      send_window(8'd50);
      check("cont_clr_slow",    32'(stress_low), 32'd1);
      check("cont_clr_continu", 32'(stress_continu), 32'd0);

      // Ready held high for 100 clocks counts as one sample.
      lv0 = lv_cnt;
      @(posedge clk);
      #2 dsp_data = 8'd0;
      dsp_ready = 1'b1;
      repeat (100) @(posedge clk);
      #2 dsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      for (int i = 0; i < 14; i++) send_sample(8'd0);
      check("held_no_early_win", 32'(lv_cnt - lv0), 32'd0);
      send_sample(8'd15);
      check("held_lvcnt", 32'(lv_cnt - lv0), 32'd1);
      check("held_level", 32'(level), 32'd0);

      // Watchdog; coincident accept and tick clears the counter.
      tick_n(60);
      check("wd60_error", 32'(error), 32'd0);
      send_sample_tick(8'd7);
      tick_n(63);
      check("wd63_error", 32'(error), 32'd0);
      tick_n(1);
      check("wd64_error", 32'(error), 32'd1);
      send_sample(8'd9);
      check("wd_sticky_error", 32'(error), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("wd_rst_error", 32'(error), 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
